// File: rtl/conv_mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate over first/last-delimited groups; result NUM_STAGE+1 cycles after last beat.
// Backpressure: a held result (out_valid && !out_ready) freezes the whole pipeline and drops in_ready.
module conv_mac_pipe #(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 13,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_ovf
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LAST = NUM_STAGE - 1;

  logic                 stall;
  logic [PW-1:0]        prod_raw;
  logic [ACC_WIDTH-1:0] prod_ext;

  logic [ACC_WIDTH-1:0] st_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0] st_vld;
  logic [NUM_STAGE-1:0] st_first;
  logic [NUM_STAGE-1:0] st_last;

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 acc_ovf_q;
  logic                 acc_empty;

  logic                 start;
  logic                 add_ovf;
  logic [ACC_WIDTH:0]   sum_w;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 ovf_nxt;
  logic                 tail_vld;
  logic                 tail_last;
  logic [ACC_WIDTH-1:0] tail_prod;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod_raw = PW'($signed(din0)) * PW'($signed(din1));
      assign prod_ext = ACC_WIDTH'($signed(prod_raw));
    end else begin : g_unsigned
      assign prod_raw = PW'(din0) * PW'(din1);
      assign prod_ext = ACC_WIDTH'(prod_raw);
    end
  endgenerate

  // Product and its group flags move as one unit; the whole line freezes on stall.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_vld   <= '0;
      st_first <= '0;
      st_last  <= '0;
      for (int i = 0; i < NUM_STAGE; i++) st_prod[i] <= '0;
    end else if (!stall) begin
      st_vld[0]   <= in_valid;
      st_first[0] <= acc_first;
      st_last[0]  <= acc_last;
      st_prod[0]  <= prod_ext;
      for (int i = 1; i < NUM_STAGE; i++) begin
        st_vld[i]   <= st_vld[i-1];
        st_first[i] <= st_first[i-1];
        st_last[i]  <= st_last[i-1];
        st_prod[i]  <= st_prod[i-1];
      end
    end
  end

  assign tail_vld  = st_vld[LAST];
  assign tail_last = st_last[LAST];
  assign tail_prod = st_prod[LAST];

  always_comb begin
    start   = st_first[LAST] || acc_empty;
    sum_w   = {1'b0, acc_q} + {1'b0, tail_prod};
    add_ovf = 1'b0;
    if (SIGNED != 0)
      add_ovf = (acc_q[ACC_WIDTH-1] == tail_prod[ACC_WIDTH-1]) &&
                (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      add_ovf = sum_w[ACC_WIDTH];
    acc_nxt = start ? tail_prod : sum_w[ACC_WIDTH-1:0];
    ovf_nxt = start ? 1'b0 : (acc_ovf_q || add_ovf);
  end

  // acc_empty makes the first beat after a result or reset load, whatever its first flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      acc_empty <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_ovf  <= 1'b0;
    end else if (!stall) begin
      if (tail_vld) begin
        acc_q     <= acc_nxt;
        acc_ovf_q <= ovf_nxt;
        acc_empty <= tail_last;
      end
      out_valid <= tail_vld && tail_last;
      if (tail_vld && tail_last) begin
        dout     <= acc_nxt;
        dout_ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: three configurations (unsigned/32, signed/32, unsigned/21) share one stimulus stream
// and are checked against an arithmetic group-sum model.
module tb_conv_mac_pipe;

  localparam int NS = 3;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        acc_first = 1'b0;
  logic        acc_last = 1'b0;
  logic [7:0]  din0 = '0;
  logic [12:0] din1 = '0;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
  logic [31:0] do0, do1;
  logic [20:0] do2;

  always #5 ap_clk = ~ap_clk;

  conv_mac_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(13), .NUM_STAGE(NS), .ACC_WIDTH(32), .SIGNED(0)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov0), .out_ready(out_ready), .dout(do0), .dout_ovf(of0));

  conv_mac_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(13), .NUM_STAGE(NS), .ACC_WIDTH(32), .SIGNED(1)) u_sgn (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov1), .out_ready(out_ready), .dout(do1), .dout_ovf(of1));

  conv_mac_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(13), .NUM_STAGE(NS), .ACC_WIDTH(21), .SIGNED(0)) u_w21 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov2), .out_ready(out_ready), .dout(do2), .dout_ovf(of2));

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
  } res_t;

  res_t   exp0[$], exp1[$], exp2[$], got0[$], got1[$], got2[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     bp_mode = 0;
  longint m_acc[3];
  bit     m_ovf[3];
  bit     m_open[3];

  // Output capture: every handshake is one delivered result.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (ov0 && out_ready) got0.push_back({do0, of0});
      if (ov1 && out_ready) got1.push_back({do1, of1});
      if (ov2 && out_ready) got2.push_back({11'b0, do2, of2});
    end
  end

  // Backpressure: 0 always ready, 1 random, 2 held low.
  always @(posedge ap_clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference: exact integer group sums, wrapped into the configuration's range.
  function automatic void model_beat(int cfg, logic [7:0] a, logic [12:0] b, bit f, bit l);
    int     w;
    longint p, s, lo, hi, md;
    res_t   r;
    w  = (cfg == 2) ? 21 : 32;
    md = 64'sd1 <<< w;
    if (cfg == 1) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = -(md / 2);
      hi = md / 2 - 1;
    end else begin
      p  = longint'(a) * longint'(b);
      lo = 0;
      hi = md - 1;
    end
    if (f || !m_open[cfg]) begin
      s = p;
      m_ovf[cfg] = 1'b0;
    end else begin
      s = m_acc[cfg] + p;
      if (s > hi) begin s = s - md; m_ovf[cfg] = 1'b1; end
      else if (s < lo) begin s = s + md; m_ovf[cfg] = 1'b1; end
    end
    m_acc[cfg]  = s;
    m_open[cfg] = !l;
    if (l) begin
      r.val = 32'(s);
      r.ovf = m_ovf[cfg];
      case (cfg)
        0:       exp0.push_back(r);
        1:       exp1.push_back(r);
        default: exp2.push_back(r);
      endcase
    end
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 3; c++) begin m_open[c] = 1'b0; m_acc[c] = 0; m_ovf[c] = 1'b0; end
    exp0.delete(); exp1.delete(); exp2.delete();
    got0.delete(); got1.delete(); got2.delete();
  endtask

  task automatic align();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [12:0] b, input bit f, input bit l);
    bit taken = 1'b0;
    din0 = a; din1 = b; acc_first = f; acc_last = l; in_valid = 1'b1;
    for (int t = 0; t < 300 && !taken; t++) begin
      @(negedge ap_clk);
      taken = rdy0 && rdy1 && rdy2;
      @(posedge ap_clk);
      #1;
    end
    if (taken) begin
      for (int c = 0; c < 3; c++) model_beat(c, a, b, f, l);
    end else begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout in_ready=%b required 1", rdy0);
    end
    in_valid = 1'b0;
    din0 = 8'($urandom); din1 = 13'($urandom);
    acc_first = 1'($urandom); acc_last = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      din0 = 8'($urandom); din1 = 13'($urandom);
      acc_first = 1'($urandom); acc_last = 1'($urandom);
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (got0.size() >= exp0.size() && got1.size() >= exp1.size() && got2.size() >= exp2.size()) break;
      @(negedge ap_clk);
    end
    repeat (NS + 3) @(negedge ap_clk);
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    bp_mode  = 0;
    repeat (3) @(negedge ap_clk);
    n_cmp++;
    if ({ov0, ov1, ov2} !== 3'b000) begin n_err++; $display("FAIL reset_out_valid got=%b required 000", {ov0, ov1, ov2}); end
    n_cmp++;
    if ({do0, do1, do2} !== 85'd0) begin n_err++; $display("FAIL reset_dout got=%h/%h/%h required 0", do0, do1, do2); end
    n_cmp++;
    if ({of0, of1, of2} !== 3'b000) begin n_err++; $display("FAIL reset_ovf got=%b required 000", {of0, of1, of2}); end
    n_cmp++;
    if (rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b required 1", rdy0); end
    ap_rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_latency();
    align();
    clear_model();
    send_beat(8'd255, 13'd8191, 1'b1, 1'b1);
    for (int k = 1; k <= NS + 2; k++) begin
      @(negedge ap_clk);
      n_cmp++;
      if (ov0 !== (k == NS + 1)) begin
        n_err++; $display("FAIL latency_valid cycle=%0d got=%b required %b", k, ov0, (k == NS + 1));
      end
      if (k == NS + 1) begin
        n_cmp++;
        if (do0 !== 32'd2088705 || of0 !== 1'b0) begin n_err++; $display("FAIL single_unsigned got=%0d ovf=%b required 2088705 ovf=0", do0, of0); end
        n_cmp++;
        if (do1 !== 32'd1) begin n_err++; $display("FAIL single_signed got=%0d required 1", do1); end
        n_cmp++;
        if (do2 !== 21'd2088705 || of2 !== 1'b0) begin n_err++; $display("FAIL single_w21 got=%0d ovf=%b required 2088705 ovf=0", do2, of2); end
      end
    end
    drain();
  endtask

  task automatic test_group_sum();
    logic signed [31:0] neg_sum = -32'sd1044352;
    align();
    clear_model();
    send_beat(8'd3, 13'd5, 1'b1, 1'b0);
    send_beat(8'd7, 13'd11, 1'b0, 1'b0);
    send_beat(8'd2, 13'd2, 1'b0, 1'b0);
    send_beat(8'd100, 13'd1000, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (got0.size() != 1 || got0[0].val !== 32'd100096) begin
      n_err++; $display("FAIL group4 results=%0d first=%0d required 1 result of 100096", got0.size(), got0[0].val);
    end
    clear_model();
    send_beat(8'h80, 13'h0FFF, 1'b1, 1'b0);
    send_beat(8'h7F, 13'h1000, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (got1.size() != 1 || got1[0].val !== neg_sum || got1[0].ovf !== 1'b0) begin
      n_err++; $display("FAIL signed_group results=%0d got=%h ovf=%b required %h ovf=0", got1.size(), got1[0].val, got1[0].ovf, neg_sum);
    end
    clear_model();
    send_beat(8'd255, 13'd8191, 1'b1, 1'b0);
    send_beat(8'd255, 13'd8191, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (got2.size() != 1 || got2[0].val !== 32'd2080258 || got2[0].ovf !== 1'b1) begin
      n_err++; $display("FAIL w21_overflow results=%0d got=%0d ovf=%b required 2080258 ovf=1", got2.size(), got2[0].val, got2[0].ovf);
    end
    n_cmp++;
    if (got0.size() != 1 || got0[0].val !== 32'd4177410 || got0[0].ovf !== 1'b0) begin
      n_err++; $display("FAIL w32_no_overflow got=%0d ovf=%b required 4177410 ovf=0", got0[0].val, got0[0].ovf);
    end
  endtask

  task automatic test_random_groups();
    int len;
    bit f;
    align();
    clear_model();
    bp_mode = 1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        f = (j == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
        send_beat(8'($urandom), 13'($urandom), f, (j == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    bp_mode = 0;
    drain();
    n_cmp++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size() || got2.size() != exp2.size()) begin
      n_err++; $display("FAIL random_count got=%0d/%0d/%0d required %0d", got0.size(), got1.size(), got2.size(), exp0.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      n_cmp++;
      if (got0[i] !== exp0[i]) begin n_err++; $display("FAIL random_u32 idx=%0d got=%h required %h", i, got0[i], exp0[i]); end
      n_cmp++;
      if (got1[i] !== exp1[i]) begin n_err++; $display("FAIL random_s32 idx=%0d got=%h required %h", i, got1[i], exp1[i]); end
      n_cmp++;
      if (got2[i] !== exp2[i]) begin n_err++; $display("FAIL random_u21 idx=%0d got=%h required %h", i, got2[i], exp2[i]); end
    end
  endtask

  task automatic test_stall();
    bit seen;
    align();
    clear_model();
    bp_mode = 0;
    fork
      begin
        for (int g = 0; g < 8; g++) begin
          int len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            send_beat(8'($urandom), 13'($urandom), (j == 0), (j == len - 1));
        end
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge ap_clk);
          seen = ov0;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL stall_first_result out_valid=%b required 1", ov0); end
        bp_mode = 2;
        @(negedge ap_clk);
        for (int k = 0; k < 10; k++) begin
          @(negedge ap_clk);
          n_cmp++;
          if (rdy0 !== !ov0) begin n_err++; $display("FAIL stall_in_ready cycle=%0d got=%b required %b", k, rdy0, !ov0); end
        end
        bp_mode = 0;
      end
    join
    drain();
    n_cmp++;
    if (exp0.size() != 8 || got0.size() != 8 || got1.size() != 8 || got2.size() != 8) begin
      n_err++; $display("FAIL stall_count got=%0d/%0d/%0d required 8", got0.size(), got1.size(), got2.size());
    end
    for (int i = 0; i < exp0.size(); i++) begin
      n_cmp++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i] || got2[i] !== exp2[i]) begin
        n_err++; $display("FAIL stall_order idx=%0d got=%h/%h/%h required %h/%h/%h", i, got0[i], got1[i], got2[i], exp0[i], exp1[i], exp2[i]);
      end
    end
  endtask

  task automatic test_reset_mid_group();
    bit seen = 1'b0;
    align();
    clear_model();
    bp_mode = 0;
    send_beat(8'd10, 13'd20, 1'b1, 1'b1);
    send_beat(8'd5, 13'd5, 1'b1, 1'b0);
    send_beat(8'd6, 13'd6, 1'b0, 1'b0);
    bp_mode = 2;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge ap_clk);
      seen = ov0;
    end
    n_cmp++;
    if (!seen || do0 !== 32'd200) begin n_err++; $display("FAIL prereset_result valid=%b got=%0d required 1/200", ov0, do0); end
    #2 ap_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov0, ov1, ov2} !== 3'b000) begin n_err++; $display("FAIL midreset_valid got=%b required 000", {ov0, ov1, ov2}); end
    n_cmp++;
    if ({do0, do1, do2} !== 85'd0 || {of0, of1, of2} !== 3'b000) begin
      n_err++; $display("FAIL midreset_dout got=%0d ovf=%b required 0", do0, of0);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    bp_mode  = 0;
    clear_model();
    align();
    send_beat(8'd7, 13'd7, 1'b0, 1'b0);
    send_beat(8'd8, 13'd8, 1'b0, 1'b1);
    drain();
    n_cmp++;
    if (got0.size() != 1 || got0[0].val !== 32'd113 || got0[0] !== exp0[0]) begin
      n_err++; $display("FAIL postreset_group results=%0d got=%0d required 1 result of 113", got0.size(), got0[0].val);
    end
    n_cmp++;
    if (got1.size() != 1 || got1[0] !== exp1[0] || got2.size() != 1 || got2[0] !== exp2[0]) begin
      n_err++; $display("FAIL postreset_other got=%h/%h required %h/%h", got1[0], got2[0], exp1[0], exp2[0]);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_group_sum();
    test_random_groups();
    test_stall();
    test_reset_mid_group();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
